nios_dbg_ocimem_ctrl: RTL and testbench
=======================================

Name: nios_dbg_ocimem_ctrl

Overview:
- Consumes the system-clock-domain debug strobes (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) from the debug-slave sysclk stage.
- Turns them into single-word Avalon-MM accesses on a debug memory port.
- Returns MonDReg, monitor_ready and monitor_error to the debug-slave TCK stage for JTAG readout.
- Sits directly downstream of the debug slave wrapper inside the CPU OCI.

Parameters:
- ADDR_W, 10, word-address width of the debug memory window.
- TIMEOUT, 255, max cycles avm_waitrequest may stall one access before abort (8-bit counter; must be 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- jdo  in  38  debug command/data word, valid in the strobe cycle only
- take_action_ocimem_a  in  1  one-cycle strobe: address/mode load (+ optional read)
- take_action_ocimem_b  in  1  one-cycle strobe: write data in jdo[34:3]
- take_no_action_ocimem_a  in  1  one-cycle strobe: host poll; streams the next read in auto-increment read mode
- MonDReg  out  32  last read data, or last written data
- monitor_ready  out  1  1 = idle and MonDReg valid
- monitor_error  out  1  sticky error flag
- avm_address  out  ADDR_W+2  byte address = {MonAReg, 2'b00}
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values:
  - MonDReg=0, MonAReg=0, monitor_ready=1, monitor_error=0.
  - avm_read=0, avm_write=0, avm_writedata=0.
  - Mode bits rd_mode=0, auto_inc=0; timeout counter=0; state=IDLE.
- Reset mid-access drops the request the next cycle; no completion and no error.
- States: IDLE, RD, WR.
- In IDLE, decode in priority order:
  1. take_action_ocimem_a:
     - MonAReg<=jdo[ADDR_W+16:17], auto_inc<=jdo[35], rd_mode<=jdo[34].
     - Clear monitor_error.
     - If jdo[34]=1: go to RD; monitor_ready<=0.
  2. take_action_ocimem_b:
     - avm_writedata<=jdo[34:3], MonDReg<=jdo[34:3].
     - Go to WR; monitor_ready<=0.
  3. take_no_action_ocimem_a with rd_mode=1 and auto_inc=1: go to RD; monitor_ready<=0.
  4. take_no_action_ocimem_a otherwise: no effect.
- ocimem_a and ocimem_b in the same cycle:
  - ocimem_a is executed; ocimem_b is dropped.
  - monitor_error is set; this overrides the clear from ocimem_a.
- Any strobe while not IDLE:
  - Strobe is ignored and monitor_error<=1.
  - Exception: take_no_action_ocimem_a while busy is silently ignored.
- RD:
  - avm_read=1 and avm_address are registered, first driven the cycle after the accepting strobe.
  - avm_read is held stable while avm_waitrequest=1.
  - On the first cycle with avm_waitrequest=0:
    - MonDReg<=avm_readdata, avm_read<=0, monitor_ready<=1, state IDLE.
    - If auto_inc=1: MonAReg<=MonAReg+1.
  - Minimum latency, strobe to monitor_ready=1: 2 cycles.
- WR:
  - Same handshake on avm_write; MonDReg is unchanged.
  - If auto_inc=1: address increments on completion.
- Address increment is modulo 2^ADDR_W: all-ones wraps to 0 with no error.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle with avm_waitrequest=1.
  - On reaching TIMEOUT: deassert request; monitor_error<=1; monitor_ready<=1; MonDReg and MonAReg unchanged; state IDLE.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then ocimem_a with jdo[34]=1, jdo[35]=0, address 0x005; slave waitrequest=0 with readdata 0xDEADBEEF -> avm_address=0x014 and avm_read for 1 cycle; MonDReg=0xDEADBEEF, monitor_ready=1 two cycles after the strobe; MonAReg stays 0x005.
- ocimem_a with address 0x3FF, auto_inc=1, rd_mode=0; then ocimem_b with jdo[34:3]=0x12345678 -> write to byte address 0xFFC with data 0x12345678; MonAReg wraps to 0x000; a second ocimem_b writes to byte address 0x000.
- Auto-increment read mode at address 0x010, then three take_no_action_ocimem_a strobes spaced 4 cycles apart -> four reads at word addresses 0x010-0x013; MonDReg tracks each readdata; monitor_error stays 0.
- Read with waitrequest held for 3 cycles -> avm_read stable for 4 cycles; completion on the 4th cycle; no error. Repeat with waitrequest stuck high -> abort after 255 cycles, monitor_error=1, monitor_ready=1, MonDReg unchanged.
- ocimem_a and ocimem_b in the same cycle -> address load executed, no write issued, monitor_error=1. A later ocimem_a clears the error. An ocimem_b during a stalled read is ignored and sets monitor_error=1.
- Assert reset while avm_write is stalled -> next cycle avm_write=0, monitor_ready=1, MonAReg=0, monitor_error=0.

Source files
------------

// File: rtl/nios_dbg_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios_dbg_ocimem_ctrl
// Purpose  : Debug memory access controller. Turns the system-clock debug
//            strobes from the debug slave into single-word Avalon-MM reads
//            and writes, and returns the result (MonDReg) and status flags
//            for JTAG readout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      system clock
//   reset                    synchronous active-high reset
//   jdo[37:0]                debug command/data word (valid with a strobe)
//   take_action_ocimem_a     address/mode load, optional read
//   take_action_ocimem_b     write data in jdo[34:3]
//   take_no_action_ocimem_a  host poll; next read in auto-increment read mode
//   MonDReg[31:0]            last read data or last written data
//   monitor_ready            idle and MonDReg valid
//   monitor_error            sticky error flag
//   avm_*                    Avalon-MM master (word accesses, byte address)
// ============================================================================
module nios_dbg_ocimem_ctrl #(
    parameter int ADDR_W  = 10,   // word-address width of the debug window
    parameter int TIMEOUT = 255   // stall cycles before abort, 1..255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Last stall count value before the abort fires.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   mon_a_q,    mon_a_d;
    logic [31:0]         mon_d_q,    mon_d_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic                ready_q,    ready_d;
    logic                error_q,    error_d;
    logic                rd_mode_q,  rd_mode_d;
    logic                auto_inc_q, auto_inc_d;
    logic                read_q,     read_d;
    logic                write_q,    write_d;
    logic [7:0]          cnt_q,      cnt_d;

    // Command bits not consumed by this block.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_comb begin
        state_d    = state_q;
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        error_d    = error_q;
        rd_mode_d  = rd_mode_q;
        auto_inc_d = auto_inc_q;
        read_d     = read_q;
        write_d    = write_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_a_d    = jdo[ADDR_W+16:17];
                    auto_inc_d = jdo[35];
                    rd_mode_d  = jdo[34];
                    // A simultaneous ocimem_b is dropped but flagged; the
                    // flag wins over the clear that ocimem_a normally does.
                    error_d    = take_action_ocimem_b;
                    if (jdo[34]) begin
                        state_d = ST_RD;
                        read_d  = 1'b1;
                        ready_d = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[34:3];
                    mon_d_d = jdo[34:3];
                    state_d = ST_WR;
                    write_d = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = 8'd0;
                end else if (take_no_action_ocimem_a && rd_mode_q && auto_inc_q) begin
                    state_d = ST_RD;
                    read_d  = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = 8'd0;
                end
            end

            ST_RD, ST_WR: begin
                // Host commands while busy are dropped; a poll is harmless.
                if (take_action_ocimem_a || take_action_ocimem_b) begin
                    error_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (state_q == ST_RD) begin
                        mon_d_d = avm_readdata;
                    end
                    if (auto_inc_q) begin
                        mon_a_d = mon_a_q + c_addr_one;   // wraps modulo 2^ADDR_W
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == c_timeout_last) begin
                    // Abandon the access; data and address stay as they were.
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mon_a_q    <= '0;
            mon_d_q    <= 32'd0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
            rd_mode_q  <= 1'b0;
            auto_inc_q <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            mon_a_q    <= mon_a_d;
            mon_d_q    <= mon_d_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rd_mode_q  <= rd_mode_d;
            auto_inc_q <= auto_inc_d;
            read_q     <= read_d;
            write_q    <= write_d;
            cnt_q      <= cnt_d;
        end
    end

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign avm_address   = {mon_a_q, 2'b00};
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_dbg_ocimem_ctrl
// Purpose  : Self-checking bench for nios_dbg_ocimem_ctrl. A table of
//            per-cycle vectors covers reads, writes, address wrap and the
//            auto-increment read stream; hand sequences cover stalls,
//            timeout, strobe collisions and reset during an access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_dbg_ocimem_ctrl;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [11:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int checks = 0;
    int errors = 0;

    nios_dbg_ocimem_ctrl #(.ADDR_W(10), .TIMEOUT(255)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ta, tb, tn;
        logic [37:0] j;
        logic        wq;
        logic [31:0] rd;
        logic [31:0] e_mond;
        logic        e_rdy, e_err, e_rd, e_wr;
        logic [11:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [37:0] mk_a(input logic ai, input logic rm, input logic [9:0] a);
        return {2'b00, ai, rm, 7'd0, a, 17'd0};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic add(input logic ta, input logic tb, input logic tn, input logic [37:0] j,
                       input logic wq, input logic [31:0] rd, input logic [31:0] em,
                       input logic er, input logic ee, input logic erd, input logic ewr,
                       input logic [11:0] ea);
        vec_t v;
        v.ta = ta; v.tb = tb; v.tn = tn; v.j = j; v.wq = wq; v.rd = rd;
        v.e_mond = em; v.e_rdy = er; v.e_err = ee; v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ta, input logic tb, input logic tn, input logic [37:0] j);
        take_action_ocimem_a    = ta;
        take_action_ocimem_b    = tb;
        take_no_action_ocimem_a = tn;
        jdo                     = j;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_all(input string nm, input logic [31:0] em, input logic er, input logic ee,
                           input logic erd, input logic ewr, input logic [11:0] ea);
        chk({nm, " MonDReg"},       MonDReg,                em);
        chk({nm, " monitor_ready"}, {31'd0, monitor_ready}, {31'd0, er});
        chk({nm, " monitor_error"}, {31'd0, monitor_error}, {31'd0, ee});
        chk({nm, " avm_read"},      {31'd0, avm_read},      {31'd0, erd});
        chk({nm, " avm_write"},     {31'd0, avm_write},     {31'd0, ewr});
        chk({nm, " avm_address"},   {20'd0, avm_address},   {20'd0, ea});
    endtask

    initial begin
        int n;
        // ta tb tn jdo waitreq readdata | MonDReg ready err rd wr addr
        // Single read at word 0x005
        add(1,0,0, mk_a(0,1,10'h005),        0, 32'hDEADBEEF, 32'h00000000, 0,0,1,0, 12'h014);
        add(0,0,0, '0,                       0, 32'hDEADBEEF, 32'hDEADBEEF, 1,0,0,0, 12'h014);
        add(0,0,0, '0,                       0, 32'h0,        32'hDEADBEEF, 1,0,0,0, 12'h014);
        // Auto-increment writes across the top of the window
        add(1,0,0, mk_a(1,0,10'h3FF),        0, 32'h0,        32'hDEADBEEF, 1,0,0,0, 12'hFFC);
        add(0,1,0, mk_b(32'h12345678),       0, 32'h0,        32'h12345678, 0,0,0,1, 12'hFFC);
        add(0,0,0, '0,                       0, 32'h0,        32'h12345678, 1,0,0,0, 12'h000);
        add(0,1,0, mk_b(32'hCAFEF00D),       0, 32'h0,        32'hCAFEF00D, 0,0,0,1, 12'h000);
        add(0,0,0, '0,                       0, 32'h0,        32'hCAFEF00D, 1,0,0,0, 12'h004);
        // Poll with rd_mode=0 has no effect
        add(0,0,1, '0,                       0, 32'h0,        32'hCAFEF00D, 1,0,0,0, 12'h004);
        // Auto-increment read stream at 0x010
        add(1,0,0, mk_a(1,1,10'h010),        0, 32'h11110000, 32'hCAFEF00D, 0,0,1,0, 12'h040);
        add(0,0,0, '0,                       0, 32'hA0000010, 32'hA0000010, 1,0,0,0, 12'h044);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000010, 1,0,0,0, 12'h044);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000010, 1,0,0,0, 12'h044);
        add(0,0,1, '0,                       0, 32'h0,        32'hA0000010, 0,0,1,0, 12'h044);
        add(0,0,0, '0,                       0, 32'hA0000011, 32'hA0000011, 1,0,0,0, 12'h048);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000011, 1,0,0,0, 12'h048);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000011, 1,0,0,0, 12'h048);
        add(0,0,1, '0,                       0, 32'h0,        32'hA0000011, 0,0,1,0, 12'h048);
        add(0,0,0, '0,                       0, 32'hA0000012, 32'hA0000012, 1,0,0,0, 12'h04C);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000012, 1,0,0,0, 12'h04C);
        add(0,0,0, '0,                       0, 32'h0,        32'hA0000012, 1,0,0,0, 12'h04C);
        add(0,0,1, '0,                       0, 32'h0,        32'hA0000012, 0,0,1,0, 12'h04C);
        add(0,0,0, '0,                       0, 32'hA0000013, 32'hA0000013, 1,0,0,0, 12'h050);

        reset = 1'b1;
        drive(0, 0, 0, '0);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        tick; tick;
        reset = 1'b0;
        chk_all("reset", 32'h0, 1, 0, 0, 0, 12'h000);
        chk("reset avm_writedata", avm_writedata, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ta, vecs[i].tb, vecs[i].tn, vecs[i].j);
            avm_waitrequest = vecs[i].wq;
            avm_readdata    = vecs[i].rd;
            tick;
            chk_all($sformatf("vec%0d", i), vecs[i].e_mond, vecs[i].e_rdy, vecs[i].e_err,
                    vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr);
        end
        chk("write data after wrap writes", avm_writedata, 32'hCAFEF00D);

        // Read stalled for 3 cycles: request held 4 cycles
        drive(1, 0, 0, mk_a(0, 1, 10'h020));
        tick;
        drive(0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall read held %0d", i), {31'd0, avm_read}, 32'd1);
            chk($sformatf("stall addr %0d", i), {20'd0, avm_address}, 32'h080);
            avm_waitrequest = (i < 3);
            avm_readdata    = 32'h5A5A0003;
            tick;
        end
        chk_all("stall done", 32'h5A5A0003, 1, 0, 0, 0, 12'h080);

        // Waitrequest stuck high: abort after TIMEOUT cycles
        drive(1, 0, 0, mk_a(0, 1, 10'h021));
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'hBAD0BAD0;
        tick;
        drive(0, 0, 0, '0);
        n = 0;
        while (avm_read && n < 300) begin
            n++;
            tick;
        end
        chk("timeout request cycles", n, 32'd255);
        chk_all("timeout", 32'h5A5A0003, 1, 1, 0, 0, 12'h084);
        avm_waitrequest = 1'b0;

        // Collision of ocimem_a and ocimem_b
        drive(1, 0, 0, mk_a(0, 0, 10'h02F));
        tick;
        chk_all("error clear", 32'h5A5A0003, 1, 0, 0, 0, 12'h0BC);
        drive(1, 1, 0, mk_a(0, 0, 10'h030));
        tick;
        chk_all("collision", 32'h5A5A0003, 1, 1, 0, 0, 12'h0C0);
        drive(0, 0, 0, '0);
        tick;
        chk_all("collision after", 32'h5A5A0003, 1, 1, 0, 0, 12'h0C0);
        drive(1, 0, 0, mk_a(0, 0, 10'h031));
        tick;
        chk_all("collision cleared", 32'h5A5A0003, 1, 0, 0, 0, 12'h0C4);

        // Strobes during a stalled read
        drive(1, 0, 0, mk_a(0, 1, 10'h032));
        avm_waitrequest = 1'b1;
        tick;
        chk_all("busy read start", 32'h5A5A0003, 0, 0, 1, 0, 12'h0C8);
        drive(0, 0, 1, '0);
        tick;
        chk_all("busy poll silent", 32'h5A5A0003, 0, 0, 1, 0, 12'h0C8);
        drive(0, 1, 0, mk_b(32'h99999999));
        tick;
        chk_all("busy ocimem_b", 32'h5A5A0003, 0, 1, 1, 0, 12'h0C8);
        drive(0, 0, 0, '0);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h32323232;
        tick;
        chk_all("busy read done", 32'h32323232, 1, 1, 0, 0, 12'h0C8);
        chk("busy ocimem_b data dropped", avm_writedata, 32'hCAFEF00D);

        // Reset during a stalled write
        drive(1, 0, 0, mk_a(1, 0, 10'h040));
        tick;
        chk_all("pre-reset load", 32'h32323232, 1, 0, 0, 0, 12'h100);
        drive(0, 1, 0, mk_b(32'h44444444));
        avm_waitrequest = 1'b1;
        tick;
        chk_all("stalled write", 32'h44444444, 0, 0, 0, 1, 12'h100);
        drive(0, 1, 0, mk_b(32'h55555555));
        tick;
        chk_all("stalled write busy b", 32'h44444444, 0, 1, 0, 1, 12'h100);
        drive(0, 0, 0, '0);
        reset = 1'b1;
        tick;
        chk_all("reset mid write", 32'h0, 1, 0, 0, 0, 12'h000);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        tick;
        chk_all("after reset", 32'h0, 1, 0, 0, 0, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
